// File: rtl/rle_block_decoder.sv
// rle_block_decoder
//   Expands run-length coded 8x8 blocks back into 64 signed coefficients.
//   Each 80-bit RLE word holds four {run, level} pairs, and pair 0 is
//   decoded first. Coefficients are packed four per 64-bit word and written
//   at block*16 + k/4.
//   Optional build macro RLE_DEC_ZIGZAG_EN: decoded coefficients land in a
//   64-entry buffer at their raster position (JPEG zigzag). After each
//   block, the buffer is dumped as 16 raster-order writes.
// Ports
//   clk, reset          : clock; asynchronous active-high reset
//   start, num_blocks   : start pulse and block count (sampled on start)
//   busy, done, err     : status; done pulses once; err flags a run overflow
//   rd_en/rd_addr/rd_data : RLE SRAM port (data valid the cycle after rd_en)
//   wr_en/wr_addr/wr_data : coefficient SRAM write port (registered)
module rle_block_decoder #(
  parameter int RUN_W  = 6,
  parameter int LVL_W  = 14,
  parameter int COEF_W = 16,
  parameter int ADDR_W = 15
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [15:0]                  num_blocks,
  output logic                         busy,
  output logic                         done,
  output logic                         err,
  output logic                         rd_en,
  output logic [ADDR_W-1:0]            rd_addr,
  input  logic [4*(RUN_W+LVL_W)-1:0]   rd_data,
  output logic                         wr_en,
  output logic [ADDR_W-1:0]            wr_addr,
  output logic [4*COEF_W-1:0]          wr_data
);
  localparam int PAIR_W = RUN_W + LVL_W;
  localparam int WORD_W = 4 * PAIR_W;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_DECODE = 3'd3;
  localparam logic [2:0] S_FILL   = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;
`ifdef RLE_DEC_ZIGZAG_EN
  localparam logic [2:0] S_DUMP   = 3'd6;
  localparam logic [5:0] ZZ_TAB [64] = '{
    0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63};
  logic [3:0]               dump_q, dump_d;
  logic signed [COEF_W-1:0] zbuf_q [64];
`else
  logic signed [COEF_W-1:0] lane0_q, lane1_q, lane2_q;
`endif

  logic [2:0]               state_q, state_d;
  logic [ADDR_W-1:0]        rd_addr_q, rd_addr_d;
  logic [15:0]              blk_q, blk_d, nblk_q, nblk_d;
  logic [5:0]               k_q, k_d;
  logic [1:0]               pidx_q, pidx_d;
  logic                     first_q, first_d;
  logic [RUN_W-1:0]         zl_q, zl_d;
  logic                     err_q, err_d;
  logic                     wr_en_q;
  logic [ADDR_W-1:0]        wr_addr_q;
  logic [4*COEF_W-1:0]      wr_data_q;
  logic [WORD_W-1:0]        word_q;
  logic [PAIR_W-1:0]        pair;
  logic [RUN_W-1:0]         run;
  logic signed [COEF_W-1:0] lvl_ext, emit_val;
  logic                     is_eob, ovf, emit, pair_end, blk_end, blk_done;

  always_comb begin
    case (pidx_q)
      2'd0:    pair = word_q[PAIR_W-1:0];
      2'd1:    pair = word_q[2*PAIR_W-1:PAIR_W];
      2'd2:    pair = word_q[3*PAIR_W-1:2*PAIR_W];
      default: pair = word_q[4*PAIR_W-1:3*PAIR_W];
    endcase
  end

  assign run     = pair[PAIR_W-1 -: RUN_W];
  assign lvl_ext = {{(COEF_W-LVL_W){pair[LVL_W-1]}}, pair[LVL_W-1:0]};
  assign is_eob  = (pair == '0);
  // The level would land past k=63.
  assign ovf     = ({1'b0, k_q} + 7'(run)) > 7'd63;

  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    blk_d     = blk_q;
    nblk_d    = nblk_q;
    k_d       = k_q;
    pidx_d    = pidx_q;
    first_d   = first_q;
    zl_d      = zl_q;
    err_d     = err_q;
    emit      = 1'b0;
    emit_val  = '0;
    pair_end  = 1'b0;
    blk_end   = 1'b0;
    blk_done  = 1'b0;
`ifdef RLE_DEC_ZIGZAG_EN
    dump_d    = dump_q;
`endif
    case (state_q)
      S_IDLE: if (start) begin
        nblk_d    = num_blocks;
        blk_d     = '0;
        rd_addr_d = '0;
        k_d       = '0;
        err_d     = 1'b0;
        state_d   = (num_blocks == 16'd0) ? S_DONE : S_FETCH;
      end
      S_FETCH: begin
        rd_addr_d = rd_addr_q + ADDR_W'(1);
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        pidx_d  = '0;
        first_d = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        emit = 1'b1;
        if (first_q && (is_eob || ovf)) begin
          // EOB or overflow: this cycle already emits the first fill zero.
          err_d = err_q | ovf;
          if (k_q == 6'd63) blk_end = 1'b1;
          else              state_d = S_FILL;
        end else if (first_q && run != '0) begin
          zl_d    = run - RUN_W'(1);
          first_d = 1'b0;
        end else if (!first_q && zl_q != '0) begin
          zl_d = zl_q - RUN_W'(1);
        end else begin
          emit_val = lvl_ext;
          pair_end = 1'b1;
        end
        if (pair_end) begin
          if (k_q == 6'd63) begin
            blk_end = 1'b1;
          end else if (pidx_q == 2'd3) begin
            state_d = S_FETCH;
          end else begin
            pidx_d  = pidx_q + 2'd1;
            first_d = 1'b1;
          end
        end
      end
      S_FILL: begin
        emit = 1'b1;
        if (k_q == 6'd63) blk_end = 1'b1;
      end
      S_DONE: state_d = S_IDLE;
`ifdef RLE_DEC_ZIGZAG_EN
      S_DUMP: begin
        dump_d = dump_q + 4'd1;
        if (dump_q == 4'd15) blk_done = 1'b1;
      end
`endif
      default: state_d = S_IDLE;
    endcase
    // k wraps from 63 to 0, so the next block starts at k=0.
    if (emit) k_d = k_q + 6'd1;
`ifdef RLE_DEC_ZIGZAG_EN
    if (blk_end) begin
      state_d = S_DUMP;
      dump_d  = '0;
    end
`else
    blk_done = blk_end;
`endif
    if (blk_done) begin
      blk_d   = blk_q + 16'd1;
      state_d = (blk_q + 16'd1 == nblk_q) ? S_DONE : S_FETCH;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      rd_addr_q <= '0;
      blk_q     <= '0;
      nblk_q    <= '0;
      k_q       <= '0;
      pidx_q    <= '0;
      first_q   <= 1'b0;
      zl_q      <= '0;
      err_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
`ifdef RLE_DEC_ZIGZAG_EN
      dump_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      rd_addr_q <= rd_addr_d;
      blk_q     <= blk_d;
      nblk_q    <= nblk_d;
      k_q       <= k_d;
      pidx_q    <= pidx_d;
      first_q   <= first_d;
      zl_q      <= zl_d;
      err_q     <= err_d;
      wr_en_q   <= 1'b0;
`ifdef RLE_DEC_ZIGZAG_EN
      dump_q    <= dump_d;
      if (state_q == S_DUMP) begin
        wr_en_q   <= 1'b1;
        wr_addr_q <= {blk_q[ADDR_W-5:0], dump_q};
        wr_data_q <= {zbuf_q[{dump_q, 2'd3}], zbuf_q[{dump_q, 2'd2}],
                      zbuf_q[{dump_q, 2'd1}], zbuf_q[{dump_q, 2'd0}]};
      end
`else
      // Lane 3 completes the word; the lower lanes come from the lane registers.
      if (emit && k_q[1:0] == 2'd3) begin
        wr_en_q   <= 1'b1;
        wr_addr_q <= {blk_q[ADDR_W-5:0], k_q[5:2]};
        wr_data_q <= {emit_val, lane2_q, lane1_q, lane0_q};
      end
`endif
    end
  end

  // Payload registers carry no reset; every slot is rewritten before use.
  always_ff @(posedge clk) begin
    if (state_q == S_WAIT) word_q <= rd_data;
`ifdef RLE_DEC_ZIGZAG_EN
    if (emit) zbuf_q[ZZ_TAB[k_q]] <= emit_val;
`else
    if (emit) begin
      case (k_q[1:0])
        2'd0:    lane0_q <= emit_val;
        2'd1:    lane1_q <= emit_val;
        2'd2:    lane2_q <= emit_val;
        default: ;
      endcase
    end
`endif
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign rd_en   = (state_q == S_FETCH);
  assign rd_addr = rd_addr_q;
  assign err     = err_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

endmodule

// File: tb/tb_rle_block_decoder.sv
module tb_rle_block_decoder;
  typedef struct packed {
    logic [14:0] a;
    logic [63:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [15:0] num_blocks = '0;
  logic        busy, done, err, rd_en, wr_en;
  logic [14:0] rd_addr, wr_addr;
  logic [79:0] rd_data = '0;
  logic [63:0] wr_data;

  logic [79:0] mem  [0:255];
  logic [63:0] cmem [0:32767];
  wr_t         exp_q [$];
  logic        exp_err;
  int          exp_rds;
  logic [14:0] exp_rd;
  int          n_chk = 0, n_fail = 0;
  bit          mon_en = 1'b0;
  int          rd_seen, done_seen, stray_wr;
  int          zz_tab [64] = '{
    0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63};

  rle_block_decoder dut (
    .clk(clk), .reset(reset), .start(start), .num_blocks(num_blocks),
    .busy(busy), .done(done), .err(err),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  // Synchronous-read RLE SRAM
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr[7:0]];

  task automatic chk(input string tag, input logic [79:0] act, input logic [79:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (wr_en) begin
        cmem[wr_addr] = wr_data;
        if (exp_q.size() == 0) chk("wr_extra", 1, 0);
        else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("wr_addr", wr_addr, e.a);
          chk("wr_data", wr_data, e.d);
        end
      end
      if (rd_en) begin
        chk("rd_addr", rd_addr, exp_rd);
        exp_rd++;
        rd_seen++;
      end
      if (done) done_seen++;
    end else if (wr_en) stray_wr++;
  end

  // Reference decoder: expand pairs into a 64-entry block, then pack 4 per word.
  task automatic build_model(input int nb);
    logic [79:0] w;
    logic [19:0] pr;
    logic [13:0] l;
    logic [15:0] c [64];
    logic [15:0] o [64];
    int          r, k, p, addr;
    wr_t         e;
    addr = 0; exp_err = 1'b0; w = '0;
    for (int b = 0; b < nb; b++) begin
      for (int i = 0; i < 64; i++) c[i] = '0;
      k = 0; p = 4;
      while (k < 64) begin
        if (p == 4) begin w = mem[addr]; addr++; p = 0; end
        pr = w[20*p +: 20];
        r  = int'(pr[19:14]);
        l  = pr[13:0];
        p++;
        if (r == 0 && l == 0) break;
        if (k + r > 63) begin exp_err = 1'b1; break; end
        k = k + r;
        c[k] = {{2{l[13]}}, l};
        k++;
      end
      for (int i = 0; i < 64; i++) begin
`ifdef RLE_DEC_ZIGZAG_EN
        o[zz_tab[i]] = c[i];
`else
        o[i] = c[i];
`endif
      end
      for (int j = 0; j < 16; j++) begin
        e.a = 15'(b * 16 + j);
        e.d = {o[4*j+3], o[4*j+2], o[4*j+1], o[4*j]};
        exp_q.push_back(e);
      end
    end
    exp_rds = addr;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = '0;
  endtask

  task automatic run_dec(input int nb, input bit poke_start);
    int cyc;
    build_model(nb);
    for (int i = 0; i < 128; i++) cmem[i] = '0;
    exp_rd = '0; rd_seen = 0; done_seen = 0; mon_en = 1'b1;
    @(negedge clk); start = 1'b1; num_blocks = 16'(nb);
    @(negedge clk); start = 1'b0; num_blocks = 16'hBEEF;
    chk("busy_after_start", busy, 1);
    cyc = 0;
    while (!done && cyc < 20000) begin
      @(negedge clk); cyc++;
      if (poke_start && cyc == 40) begin start = 1'b1; num_blocks = 16'd5; end
      else start = 1'b0;
    end
    start = 1'b0;
    chk("done_seen_in_budget", done, 1);
    repeat (3) @(negedge clk);
    chk("sb_empty", exp_q.size(), 0);
    chk("done_pulses", done_seen, 1);
    chk("rd_count", rd_seen, exp_rds);
    chk("err", err, exp_err);
    chk("busy_idle", busy, 0);
    exp_q.delete();
    mon_en = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [19:0] pr;
    int          x;
    clear_mem();
    #1 reset = 1'b1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Single level then EOB
    clear_mem();
    mem[0] = {20'h0, 20'h0, 20'h0, 20'h00005};
    run_dec(1, 1'b0);
    chk("t1_word0", cmem[0], 64'h0000_0000_0000_0005);
    chk("t1_word15", cmem[15], 64'h0);

    // Run of two zeros then a negative level
    clear_mem();
    mem[0] = {60'h0, 20'hBFFD};
    run_dec(1, 1'b0);
`ifdef RLE_DEC_ZIGZAG_EN
    chk("t2_word2", cmem[2], 64'h0000_0000_0000_FFFD);
`else
    chk("t2_word0", cmem[0], 64'h0000_FFFD_0000_0000);
`endif

    // Sixteen full words, no EOB; also a start pulse while busy
    clear_mem();
    for (int i = 0; i < 16; i++) mem[i] = {4{20'h00001}};
    run_dec(1, 1'b1);
    chk("t3_word0", cmem[0], 64'h0001_0001_0001_0001);
    chk("t3_word15", cmem[15], 64'h0001_0001_0001_0001);

    // Run overflow in block 0, normal block 1
    clear_mem();
    mem[0] = {40'h0, 20'hFC007, 20'h00004};
    mem[1] = {60'h0, 20'h00002};
    run_dec(2, 1'b0);
    chk("t4_err", err, 1);
    chk("t4_word0", cmem[0], 64'h0000_0000_0000_0004);
    chk("t4_word16", cmem[16], 64'h0000_0000_0000_0002);

    // Zero blocks
    clear_mem();
    run_dec(0, 1'b0);

    // Run of two then +9
    clear_mem();
    mem[0] = {60'h0, 20'h08009};
    run_dec(1, 1'b0);
`ifdef RLE_DEC_ZIGZAG_EN
    chk("t6_word2", cmem[2], 64'h0000_0000_0000_0009);
`else
    chk("t6_word0", cmem[0], 64'h0000_0009_0000_0000);
`endif

    // Reset in the middle of block 1, then a clean rerun
    clear_mem();
    for (int i = 0; i < 16; i++)
      mem[i] = {20'(4*i+3), 20'(4*i+2), 20'(4*i+1), 20'(4*i+4)};
    mem[16] = {20'h0, 20'h0C123, 20'h00064, 20'h7FFF9};
    mem[17] = {40'h0, 20'h0, 20'h16000};
    mon_en = 1'b0;
    @(negedge clk); start = 1'b1; num_blocks = 16'd3;
    @(negedge clk); start = 1'b0;
    repeat (130) @(negedge clk);
    @(posedge clk); #2 reset = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_wr_en", wr_en, 0);
    chk("mid_rst_wr_addr", wr_addr, 0);
    chk("mid_rst_wr_data", wr_data, 0);
    chk("mid_rst_rd_addr", rd_addr, 0);
    stray_wr = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("no_writes_after_reset", stray_wr, 0);
    run_dec(3, 1'b0);

    // Random pairs, including EOBs and large runs
    for (int t = 0; t < 2; t++) begin
      clear_mem();
      for (int w = 0; w < 64; w++) begin
        for (int p = 0; p < 4; p++) begin
          x = $urandom_range(0, 15);
          if (x == 0)      pr = 20'h0;
          else if (x == 1) pr = {6'd60, 14'($urandom_range(1, 16383))};
          else             pr = {6'($urandom_range(0, 5)), 14'($urandom_range(1, 16383))};
          mem[w][20*p +: 20] = pr;
        end
      end
      run_dec(4, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/rle_block_decoder.md
Name: rle_block_decoder

Overview:
- Inverse of the run-length encoding stage. Reads 80-bit RLE words from the RLE output SRAM (32768x80).
- Expands each block back to 64 signed 16-bit DCT coefficients.
- Writes the coefficients as 64-bit words, 4 coefficients per word, 16 words per block, into a 32768x64 coefficient SRAM.
- Used to close the loop on the encoder for self-checking and as the front end of a future IDCT path.

Parameters:
- RUN_W, 6, run-length field width; max run 63.
- LVL_W, 14, signed level field width (two's complement).
- COEF_W, 16, output coefficient width; level is sign-extended to this width.
- ADDR_W, 15, address width of both SRAMs.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- start  input  1  single-cycle pulse; begins decoding at RLE address 0 / output address 0.
- num_blocks  input  16  number of 8x8 blocks to decode; sampled on start.
- busy  output  1  high from the cycle after start until done.
- done  output  1  one-cycle pulse when the last block has been written.
- err  output  1  sticky run-overflow flag; cleared by reset or start.
- rd_en  output  1  RLE SRAM read enable.
- rd_addr  output  ADDR_W  RLE SRAM word address.
- rd_data  input  80  RLE word; valid the cycle after rd_en (synchronous read).
- wr_en  output  1  coefficient SRAM write enable.
- wr_addr  output  ADDR_W  coefficient SRAM word address = block*16 + k/4.
- wr_data  output  64  packed coefficients; lane k%4 at bits [16*(k%4)+15 : 16*(k%4)].

Behaviour:
- Reset values: busy, done, err, rd_en, wr_en = 0; rd_addr, wr_addr, wr_data = 0; FSM = IDLE.
- RLE word format: 4 pairs, pair p at bits [20p+19:20p]. Each pair is {run[19:14], level[13:0]}. Pair 0 is processed first.
- Pair (r, l), l != 0, emits r zero coefficients, then sign-extended l: r+1 cycles, one coefficient per cycle.
- EOB: a pair with r=0 and l=0. Zero-fills up to k=63; the remaining pairs of that word are ignored.
- Every block starts on a fresh RLE word. rd_addr increments once per word fetched and never resets between blocks.
- A block also ends when the coefficient at k=63 is emitted without an EOB. Leftover pairs in the current word are ignored.
- Run overflow (k + r > 63):
  - set err;
  - zero-fill the rest of the block;
  - skip the rest of the word;
  - continue with the next block.
- FSM states:
  - IDLE: start with num_blocks=0 -> DONE; start otherwise -> FETCH.
  - FETCH: rd_en=1 for one cycle -> WAIT.
  - WAIT: register rd_data -> DECODE.
  - DECODE: emit coefficients. Word exhausted mid-block -> FETCH. Block complete -> FETCH, or DONE after the last block.
  - FILL: zero emission for EOB or overflow; shares the coefficient counter with DECODE.
  - DONE: done=1 for one cycle -> IDLE.
- Packing and writes:
  - wr_en pulses when lane 3 fills, i.e. the cycle after the coefficient with k%4=3 is emitted.
  - wr_data is registered.
  - Output order equals scan order unless ZIGZAG_EN is defined.
- Throughput: 1 coefficient/cycle plus a 2-cycle fetch bubble per RLE word.
- start while busy is ignored.
- Asynchronous reset mid-operation aborts immediately with no further writes. A subsequent start decodes from address 0.

Optional Feature:
- Macro: RLE_DEC_ZIGZAG_EN.
- Defined:
  - decoded coefficients are stored into a 64x16 register buffer at the raster index given by the standard JPEG zigzag table (scan 0,1,2,3 -> raster 0,1,8,16);
  - after the block completes, 16 write cycles dump the buffer in raster order;
  - adds 16 cycles per block; the next fetch starts after the dump.
- Undefined: no buffer; coefficients are written in scan order as they are decoded.

Test Plan:
- num_blocks=1; word0 = pair0 (0,+5), pair1 EOB -> wr_addr 0 data 0x0000000000000005; addrs 1..15 data 0; done pulses once; err=0.
- num_blocks=1; word0 = pair0 (2,-3), pair1 EOB -> wr_addr 0 data 0x0000FFFD00000000; no ZIGZAG_EN.
- num_blocks=1; RLE words 0..15 each hold four (0,+1) pairs, no EOB -> rd_addr 0..15 read; 16 writes of 0x0001000100010001; block ends at k=63.
- num_blocks=2; block0 word0 = (0,+4),(63,7); block1 word1 = (0,+2), EOB -> err=1; block0 wr_addr 0 = 0x0000000000000004, rest 0; wr_addr 16 = 0x0000000000000002.
- num_blocks=3; reset asserted during block 1 -> outputs return to 0 immediately, no writes after reset; new start reproduces the full 3-block result.
- RLE_DEC_ZIGZAG_EN defined; word0 = (2,+9), EOB -> scan index 2 maps to raster 8 -> wr_addr 2 bits[15:0]=0x0009, all other words 0.
